// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: two-requester round-robin arbiter feeding a serial
// overlapping 10010 pattern scanner.
// Each grant loads one DATA_W word, shifts it out MSB first through a Moore
// detector, and reports the number of matches on a one-cycle done pulse.
// Optional macro SEQ_CARRY_EN: when defined, the detector state carries over
// from one word to the next, so a match that straddles a word boundary is
// counted in the later word. When undefined, each word is scanned from idle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; busy low
// ST_SHIFT | one word bit consumed per edge, DATA_W edges in total
// ST_DONE  | done pulse; result registers hold the new word's count
module seq_scan_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic              busy,
    output logic              done,
    output logic              gnt_id,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        D_IDLE,
        D_1,
        D_10,
        D_100,
        D_1001,
        D_10010
    } det_t;

    state_t             state_q, state_d;
    det_t               det_q, det_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               last_gnt_q, last_gnt_d;
    logic               cur_gnt_q, cur_gnt_d;
    logic               gnt_id_q, gnt_id_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;

    // Overlapping Moore detector transition: each state is the longest
    // suffix of the input so far that is also a prefix of 10010.
    function automatic det_t det_next(input det_t s, input logic b);
        det_t n;
        case (s)
            D_IDLE:  n = b ? D_1    : D_IDLE;
            D_1:     n = b ? D_1    : D_10;
            D_10:    n = b ? D_1    : D_100;
            D_100:   n = b ? D_1001 : D_IDLE;
            D_1001:  n = b ? D_1    : D_10010;
            D_10010: n = b ? D_1    : D_100;
            default: n = D_IDLE;
        endcase
        return n;
    endfunction

    logic       want;
    logic       grant;
    logic       sel;
    det_t       det_nx;
    logic [CNT_W-1:0] acc_nx;

    // Next-state, arbitration and scan datapath.
    always_comb begin
        state_d     = state_q;
        det_d       = det_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        acc_d       = acc_q;
        match_cnt_d = match_cnt_q;
        last_gnt_d  = last_gnt_q;
        cur_gnt_d   = cur_gnt_q;
        gnt_id_d    = gnt_id_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        det_nx      = det_next(det_q, shreg_q[DATA_W-1]);
        acc_nx      = acc_q;

        want = req0 | req1;
        // Both requesting: the one not granted last wins. Otherwise the
        // single requester wins.
        sel  = (req0 & req1) ? ~last_gnt_q : req1;
        // The DONE cycle is also an arbitration point so back-to-back words
        // are spaced DATA_W+1 cycles apart.
        grant = want & ((state_q == ST_IDLE) | (state_q == ST_DONE));

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                det_d = det_nx;
                if ((det_nx == D_10010) && (acc_q != CNT_MAX)) begin
                    acc_nx = acc_q + CNT_W'(1);
                end
                acc_d     = acc_nx;
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d     = ST_DONE;
                    gnt_id_d    = cur_gnt_q;
                    match_cnt_d = acc_nx;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant) begin
            state_d    = ST_SHIFT;
            cur_gnt_d  = sel;
            last_gnt_d = sel;
            shreg_d    = sel ? data1 : data0;
            bit_cnt_d  = '0;
            acc_d      = '0;
`ifndef SEQ_CARRY_EN
            det_d      = D_IDLE;
`endif
            ack0_d     = ~sel;
            ack1_d     = sel;
        end
    end

    // State and datapath registers; last_gnt resets to 1 so requester 0
    // holds priority after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            det_q       <= D_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            acc_q       <= '0;
            match_cnt_q <= '0;
            last_gnt_q  <= 1'b1;
            cur_gnt_q   <= 1'b0;
            gnt_id_q    <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            det_q       <= det_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_q       <= acc_d;
            match_cnt_q <= match_cnt_d;
            last_gnt_q  <= last_gnt_d;
            cur_gnt_q   <= cur_gnt_d;
            gnt_id_q    <= gnt_id_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign gnt_id    = gnt_id_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Testbench for seq_scan_arbiter: reset values, directed scenarios, a vector
// table, randomized rounds against a bit-history model, and a saturation
// check on a second wide/narrow-counter instance.
module tb_seq_scan_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, busy, done, gnt_id;
    logic [3:0] match_cnt;

    logic        s_req0, s_req1;
    logic [15:0] s_data0, s_data1;
    logic        s_ack0, s_ack1, s_busy, s_done, s_gnt;
    logic [1:0]  s_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: window of the last five scanned bits and how many
    // bits the detector has seen since it was last cleared.
    logic [4:0] m_win;
    int         m_len;
    logic       m_last;

    typedef struct {
        logic       sel;
        logic [7:0] data;
        int         exp_cnt;
    } vec_t;
    vec_t tbl[8];

    seq_scan_arbiter #(.DATA_W(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .busy(busy), .done(done), .gnt_id(gnt_id), .match_cnt(match_cnt)
    );

    seq_scan_arbiter #(.DATA_W(16), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .req0(s_req0), .data0(s_data0), .ack0(s_ack0),
        .req1(s_req1), .data1(s_data1), .ack1(s_ack1),
        .busy(s_busy), .done(s_done), .gnt_id(s_gnt), .match_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic model_scan(input logic [7:0] w, output int cnt);
`ifndef SEQ_CARRY_EN
        m_len = 0;
`endif
        cnt = 0;
        for (int i = 7; i >= 0; i--) begin
            m_win = {m_win[3:0], w[i]};
            m_len++;
            if (m_len >= 5 && m_win == 5'b10010 && cnt < 15) cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; s_req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_len = 0; m_win = '0; m_last = 1'b1;
    endtask

    // Raise the selected requests and serve them; each requester drops its
    // request on its ack. Returns ack order and the result at each done.
    task automatic serve(input logic r0, input logic r1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         output int a0, output int g0, output int c0,
                         output int a1, output int g1, output int c1);
        int n;
        int t;
        int aid[2];
        int gid[2];
        int cid[2];
        aid = '{-1, -1}; gid = '{-1, -1}; cid = '{-1, -1};
        req0 = r0; data0 = d0; req1 = r1; data1 = d1;
        n = int'(r0) + int'(r1);
        for (int k = 0; k < n; k++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(ack0 || ack1) && t < 30);
            if (!(ack0 || ack1)) begin
                chk("ack_timeout", 0, 1);
                break;
            end
            chk("ack_onehot", int'(ack0) + int'(ack1), 1);
            aid[k] = ack1 ? 1 : 0;
            if (ack1) req1 = 1'b0; else req0 = 1'b0;
            t = 0;
            while (!done && t < 30) begin
                @(negedge clk);
                t++;
            end
            if (!done) begin
                chk("done_timeout", 0, 1);
                break;
            end
            gid[k] = int'(gnt_id);
            cid[k] = int'(match_cnt);
        end
        req0 = 1'b0; req1 = 1'b0;
        a0 = aid[0]; g0 = gid[0]; c0 = cid[0];
        a1 = aid[1]; g1 = gid[1]; c1 = cid[1];
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_ack0"}, int'(ack0), 0);
        chk({nm, "_ack1"}, int'(ack1), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_gnt"}, int'(gnt_id), 0);
        chk({nm, "_cnt"}, int'(match_cnt), 0);
    endtask

    task automatic test_basic();
        int dly;
        int a0, g0, c0, a1, g1, c1;
        do_reset();
        // Single req0 with two overlapping matches; timing checked exactly.
        req0 = 1'b1; data0 = 8'b10010010;
        @(negedge clk);
        chk("r030_ack0", int'(ack0), 1);
        chk("r030_busy", int'(busy), 1);
        req0 = 1'b0;
        dly = 0;
        while (!done && dly < 20) begin
            @(negedge clk);
            dly++;
            if (dly < 8 && done) chk("r030_early_done", 1, 0);
        end
        chk("r030_done_lat", dly, 8);
        chk("r030_cnt", int'(match_cnt), 2);
        chk("r030_gnt", int'(gnt_id), 0);
        @(negedge clk);
        chk("r030_done_pulse", int'(done), 0);
        chk("r030_idle_busy", int'(busy), 0);
        chk("r030_hold_cnt", int'(match_cnt), 2);

        serve(1'b0, 1'b1, 8'h00, 8'h00, a0, g0, c0, a1, g1, c1);
        chk("r031_ack_id", a0, 1);
        chk("r031_gnt_00", g0, 1);
        chk("r031_cnt_00", c0, 0);
        serve(1'b0, 1'b1, 8'h00, 8'hFF, a0, g0, c0, a1, g1, c1);
        chk("r031_gnt_ff", g0, 1);
        chk("r031_cnt_ff", c0, 0);

        serve(1'b1, 1'b0, 8'b00000100, 8'h00, a0, g0, c0, a1, g1, c1);
        chk("r033_first_cnt", c0, 0);
        serve(1'b1, 1'b0, 8'b10000000, 8'h00, a0, g0, c0, a1, g1, c1);
        chk("r033_gnt", g0, 0);
`ifdef SEQ_CARRY_EN
        chk("r033_second_cnt", c0, 1);
`else
        chk("r033_second_cnt", c0, 0);
`endif
    endtask

    task automatic test_both_held();
        int cyc, nack, ndone, exp;
        int ack_id[4];
        int ack_cyc[4];
        int d_gnt[4];
        int d_cnt[4];
        do_reset();
        cyc = 0; nack = 0; ndone = 0;
        req0 = 1'b1; req1 = 1'b1; data0 = 8'b10010010; data1 = 8'h49;
        while (ndone < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if ((ack0 || ack1) && nack < 4) begin
                ack_id[nack]  = ack1 ? 1 : 0;
                ack_cyc[nack] = cyc;
                nack++;
            end
            if (done && ndone < 4) begin
                d_gnt[ndone] = int'(gnt_id);
                d_cnt[ndone] = int'(match_cnt);
                ndone++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("r032_nack", nack, 4);
        chk("r032_ndone", ndone, 4);
        for (int k = 0; k < nack; k++) begin
            chk("r032_ack_order", ack_id[k], k % 2);
            if (k > 0) chk("r032_ack_spacing", int'(ack_cyc[k] - ack_cyc[k-1] >= 9), 1);
        end
        for (int k = 0; k < ndone; k++) begin
            model_scan((k % 2) ? data1 : data0, exp);
            chk("r032_gnt", d_gnt[k], k % 2);
            chk("r032_cnt", d_cnt[k], exp);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int seen;
        int a0, g0, c0, a1, g1, c1;
        do_reset();
        req0 = 1'b1; data0 = 8'hFF;
        @(negedge clk);
        chk("r034_ack0", int'(ack0), 1);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("r034_async");
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("r034_no_done", seen, 0);
        serve(1'b1, 1'b0, 8'b10010000, 8'h00, a0, g0, c0, a1, g1, c1);
        chk("r034_after_gnt", g0, 0);
        chk("r034_after_cnt", c0, 1);
    endtask

    task automatic test_table();
        int a0, g0, c0, a1, g1, c1;
        tbl[0] = '{1'b0, 8'b10010000, 1};
        tbl[1] = '{1'b1, 8'b01001000, 1};
        tbl[2] = '{1'b1, 8'b11111000, 0};
        tbl[3] = '{1'b0, 8'b00000000, 0};
        tbl[4] = '{1'b0, 8'b10011000, 0};
        tbl[5] = '{1'b1, 8'b00100000, 0};
        tbl[6] = '{1'b1, 8'b10010000, 1};
        tbl[7] = '{1'b0, 8'b01001000, 1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            serve(~tbl[i].sel, tbl[i].sel, tbl[i].data, tbl[i].data,
                  a0, g0, c0, a1, g1, c1);
            chk($sformatf("tbl%0d_ack", i), a0, int'(tbl[i].sel));
            chk($sformatf("tbl%0d_gnt", i), g0, int'(tbl[i].sel));
            chk($sformatf("tbl%0d_cnt", i), c0, tbl[i].exp_cnt);
        end
    endtask

    task automatic test_random();
        int pat, first, second, e0, e1;
        logic r0, r1;
        logic [7:0] d0, d1;
        int a0, g0, c0, a1, g1, c1;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            pat = int'($urandom_range(0, 2));
            r0 = (pat != 1);
            r1 = (pat != 0);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            if (r0 && r1) first = m_last ? 0 : 1;
            else first = r1 ? 1 : 0;
            second = 1 - first;
            model_scan(first ? d1 : d0, e0);
            m_last = first[0];
            serve(r0, r1, d0, d1, a0, g0, c0, a1, g1, c1);
            chk("rnd_ack0", a0, first);
            chk("rnd_gnt0", g0, first);
            chk("rnd_cnt0", c0, e0);
            if (r0 && r1) begin
                model_scan(second ? d1 : d0, e1);
                m_last = second[0];
                chk("rnd_ack1", a1, second);
                chk("rnd_gnt1", g1, second);
                chk("rnd_cnt1", c1, e1);
            end
        end
    endtask

    task automatic test_saturation();
        int t;
        do_reset();
        s_req0 = 1'b1; s_data0 = 16'b1001001001001001;
        @(negedge clk);
        chk("sat_ack0", int'(s_ack0), 1);
        s_req0 = 1'b0;
        t = 0;
        while (!s_done && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("sat_done_lat", t, 16);
        chk("sat_cnt", int'(s_cnt), 3);
        chk("sat_gnt", int'(s_gnt), 0);
    endtask

    initial begin
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        s_req0 = 1'b0; s_req1 = 1'b0; s_data0 = '0; s_data1 = '0;
        m_len = 0; m_win = '0; m_last = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        test_basic();
        test_both_held();
        test_reset_abort();
        test_table();
        test_random();
        test_saturation();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
